// File: rtl/axi_ad9434_up_axi_pkg.sv
// Shared definitions for the AD9434 AXI4-Lite to up-bus bridge: FSM encoding,
// response codes and the fill word returned on a timed-out read.
package axi_ad9434_up_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_WWAIT = 3'd2,
    ST_WRESP = 3'd3,
    ST_RREQ  = 3'd4,
    ST_RWAIT = 3'd5,
    ST_RRESP = 3'd6
  } up_axi_state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] RDATA_TIMEOUT = 32'hDEAD_DEAD;
  localparam int          UP_ADDR_W     = 14;

endpackage

// File: rtl/axi_ad9434_up_axi.sv
// AXI4-Lite slave bridged onto the single-outstanding up-bus, with an ack
// timeout that turns a silent core into a SLVERR response.
//
// state | meaning
// IDLE  | readies raised for one cycle when a full write (or else a read) is pending
// WREQ  | up_wreq high for one cycle, address and data stable
// WWAIT | waiting for up_wack, timeout counter running
// WRESP | bvalid held until bready
// RREQ  | up_rreq high for one cycle, address stable
// RWAIT | waiting for up_rack, timeout counter running
// RRESP | rvalid held until rready
module axi_ad9434_up_axi
  import axi_ad9434_up_axi_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                         up_clk,
  input  logic                         up_rstn,

  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_awaddr,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic [1:0]                   s_axi_bresp,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_araddr,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [31:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,

  output logic                         up_wreq,
  output logic [UP_ADDR_W-1:0]         up_waddr,
  output logic [31:0]                  up_wdata,
  input  logic                         up_wack,
  output logic                         up_rreq,
  output logic [UP_ADDR_W-1:0]         up_raddr,
  input  logic [31:0]                  up_rdata,
  input  logic                         up_rack
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  up_axi_state_e        state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 awready_q;
  logic                 wready_q;
  logic                 arready_q;
  logic                 bvalid_q;
  logic [1:0]           bresp_q;
  logic                 rvalid_q;
  logic [1:0]           rresp_q;
  logic [31:0]          rdata_q;
  logic                 up_wreq_q;
  logic                 up_rreq_q;
  logic [UP_ADDR_W-1:0] up_waddr_q;
  logic [UP_ADDR_W-1:0] up_raddr_q;
  logic [31:0]          up_wdata_q;

  logic wr_pending;
  assign wr_pending = s_axi_awvalid & s_axi_wvalid;

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      up_wreq_q  <= 1'b0;
      up_rreq_q  <= 1'b0;
      up_waddr_q <= '0;
      up_raddr_q <= '0;
      up_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Readies are registered: raised one cycle, the handshake completes on the next edge.
          if (awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            if (wr_pending) begin
              up_waddr_q <= s_axi_awaddr[15:2];
              up_wdata_q <= s_axi_wdata;
              up_wreq_q  <= 1'b1;
              state_q    <= ST_WREQ;
            end
          end else if (arready_q) begin
            arready_q <= 1'b0;
            if (s_axi_arvalid) begin
              up_raddr_q <= s_axi_araddr[15:2];
              up_rreq_q  <= 1'b1;
              state_q    <= ST_RREQ;
            end
          end else if (wr_pending) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end else if (s_axi_arvalid) begin
            arready_q <= 1'b1;
          end
        end

        ST_WREQ: begin
          up_wreq_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_WWAIT;
        end

        ST_WWAIT: begin
          if (up_wack) begin
            bvalid_q <= 1'b1;
            bresp_q  <= RESP_OKAY;
            state_q  <= ST_WRESP;
          end else if (cnt_q == CNT_LAST) begin
            bvalid_q <= 1'b1;
            bresp_q  <= RESP_SLVERR;
            state_q  <= ST_WRESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_WRESP: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            state_q  <= ST_IDLE;
          end
        end

        ST_RREQ: begin
          up_rreq_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_RWAIT;
        end

        ST_RWAIT: begin
          if (up_rack) begin
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= up_rdata;
            state_q  <= ST_RRESP;
          end else if (cnt_q == CNT_LAST) begin
            rvalid_q <= 1'b1;
            rresp_q  <= RESP_SLVERR;
            rdata_q  <= RDATA_TIMEOUT;
            state_q  <= ST_RRESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RRESP: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            state_q  <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign up_wreq       = up_wreq_q;
  assign up_rreq       = up_rreq_q;
  assign up_waddr      = up_waddr_q;
  assign up_raddr      = up_raddr_q;
  assign up_wdata      = up_wdata_q;

  // Byte lanes and sub-word address bits have no meaning on the up-bus.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule
